i2c_reg_sequencer: RTL and testbench

// - Sequences one i2c_master for 8-bit register accesses: single-byte write (S,dev+W,reg,data,P) or read (S,dev+W,reg,Sr,dev+R,data,P).
// - Accepts one request at a time over a valid/ready handshake; returns read data and error status as a one-cycle response.
// - Sits between board-management logic (PMIC/codec/RTC setup) and i2c_master; sole driver of master address/data_tx/transfer_start/transfer_continues.

---
 rtl/i2c_reg_sequencer.sv | 207 ++++++++++++++++++++
 tb/tb_i2c_reg_sequencer.sv | 361 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_reg_sequencer.sv
// Drives one i2c_master through single-byte register writes and reads over a valid/ready port.
// Optional macro I2C_SEQ_RETRY_EN re-runs NACKed or arbitration-lost accesses up to MAX_RETRIES.
module i2c_reg_sequencer #(
    parameter int unsigned TIMEOUT_CYCLES = 1000000,
    parameter int unsigned MAX_RETRIES    = 3
) (
    input  logic       clk_in,
    input  logic       reset,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic       req_rw,
    input  logic [6:0] req_dev,
    input  logic [7:0] req_reg,
    input  logic [7:0] req_wdata,
    output logic       resp_valid,
    output logic [7:0] resp_rdata,
    output logic [1:0] resp_err,
    output logic [7:0] m_address,
    output logic       m_transfer_start,
    output logic       m_transfer_cont,
    output logic [7:0] m_data_tx,
    input  logic       m_transfer_ready,
    input  logic       m_interrupt,
    input  logic       m_trans_complete,
    input  logic       m_nack,
    input  logic [7:0] m_data_rx,
    input  logic       m_address_err,
    input  logic       m_arb_err
);

    localparam int unsigned TimerW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TimerW-1:0] TimeoutMax  = TimerW'(TIMEOUT_CYCLES);
    localparam logic [TimerW-1:0] TimeoutLast = TimerW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        StIdle, StWaitBus, StReg, StRstart, StWdata, StRdata, StDone
    } state_e;

    state_e            state_q, state_d;
    logic              rw_q;
    logic [6:0]        dev_q;
    logic [7:0]        reg_q, wdata_q;
    logic [7:0]        rdata_q, rdata_d;
    logic [1:0]        err_q, err_d;
    logic [TimerW-1:0] timer_q, timer_d;
    logic              accept;
    logic              active;
    logic              xfer_done;
    logic [1:0]        fault;

`ifdef I2C_SEQ_RETRY_EN
    localparam int unsigned RetryW = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1;
    localparam logic [RetryW-1:0] RetryMax = RetryW'(MAX_RETRIES);
    logic [RetryW-1:0] retry_q, retry_d;
`else
    logic unused_max_retries;
    assign unused_max_retries = ^32'(MAX_RETRIES);
`endif

    assign xfer_done  = m_interrupt & m_trans_complete;
    assign active     = (state_q != StIdle) && (state_q != StDone);
    assign resp_rdata = rdata_q;
    assign resp_err   = err_q;

    always_comb begin
        state_d          = state_q;
        err_d            = err_q;
        rdata_d          = rdata_q;
        accept           = 1'b0;
        fault            = 2'd0;
        req_ready        = 1'b0;
        resp_valid       = 1'b0;
        m_address        = 8'h00;
        m_data_tx        = 8'h00;
        m_transfer_start = 1'b0;
        m_transfer_cont  = 1'b0;
`ifdef I2C_SEQ_RETRY_EN
        retry_d          = retry_q;
`endif
        unique case (state_q)
            StIdle: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    accept  = 1'b1;
                    err_d   = 2'd0;
                    rdata_d = 8'h00;
                    state_d = StWaitBus;
`ifdef I2C_SEQ_RETRY_EN
                    retry_d = '0;
`endif
                end
            end
            StWaitBus: begin
                m_address        = {dev_q, 1'b0};
                m_data_tx        = reg_q;
                m_transfer_start = 1'b1;
                m_transfer_cont  = 1'b1;
                if (m_transfer_ready) state_d = StReg;
            end
            StReg: begin
                m_address       = {dev_q, 1'b0};
                m_data_tx       = reg_q;
                m_transfer_cont = 1'b1;
                if (xfer_done) state_d = rw_q ? StRstart : StWdata;
            end
            StRstart: begin
                // Repeated start with the read address; one byte only, so no continue.
                m_address        = {dev_q, 1'b1};
                m_data_tx        = reg_q;
                m_transfer_start = 1'b1;
                if (xfer_done) state_d = StRdata;
            end
            StWdata: begin
                m_address = {dev_q, 1'b0};
                m_data_tx = wdata_q;
                if (xfer_done) state_d = StDone;
            end
            StRdata: begin
                m_address = {dev_q, 1'b1};
                if (xfer_done) begin
                    rdata_d = m_data_rx;
                    state_d = StDone;
                end
            end
            StDone: begin
                resp_valid = 1'b1;
                state_d    = StIdle;
            end
            default: state_d = StIdle;
        endcase

        // The master NACKs the single read byte itself, so that NACK is not a fault.
        if (active) begin
            if (m_arb_err) begin
                fault = 2'd2;
            end else if (m_address_err) begin
                fault = 2'd1;
            end else if (xfer_done && m_nack && (state_q != StRdata)) begin
                fault = 2'd1;
            end
        end

        if (fault != 2'd0) begin
            rdata_d = 8'h00;
`ifdef I2C_SEQ_RETRY_EN
            if (retry_q < RetryMax) begin
                retry_d = retry_q + RetryW'(1);
                state_d = StWaitBus;
            end else begin
                err_d   = fault;
                state_d = StDone;
            end
`else
            err_d   = fault;
            state_d = StDone;
`endif
        end else if (active && (timer_q == TimeoutLast) && !m_interrupt) begin
            err_d   = 2'd3;
            rdata_d = 8'h00;
            state_d = StDone;
        end
    end

    always_comb begin
        timer_d = timer_q;
        if (accept) begin
            timer_d = '0;
        end else if (state_q != StIdle) begin
            if (m_interrupt) begin
                timer_d = '0;
            end else if (timer_q != TimeoutMax) begin
                timer_d = timer_q + TimerW'(1);
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (reset) begin
            state_q <= StIdle;
            rw_q    <= 1'b0;
            dev_q   <= 7'h00;
            reg_q   <= 8'h00;
            wdata_q <= 8'h00;
            rdata_q <= 8'h00;
            err_q   <= 2'd0;
            timer_q <= '0;
`ifdef I2C_SEQ_RETRY_EN
            retry_q <= '0;
`endif
        end else begin
            state_q <= state_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            timer_q <= timer_d;
`ifdef I2C_SEQ_RETRY_EN
            retry_q <= retry_d;
`endif
            if (accept) begin
                rw_q    <= req_rw;
                dev_q   <= req_dev;
                reg_q   <= req_reg;
                wdata_q <= req_wdata;
            end
        end
    end

endmodule

// File: tb/tb_i2c_reg_sequencer.sv
// Randomized bench for i2c_reg_sequencer: a simple i2c_master/slave responder plus a
// transaction-level expectation of bus tokens, response code, read data and timeout latency.
`timescale 1ns/1ps
module tb_i2c_reg_sequencer;

    localparam int unsigned TimeoutCycles = 64;
    localparam int unsigned MaxRetries    = 3;
`ifdef I2C_SEQ_RETRY_EN
    localparam int Attempts = MaxRetries + 1;
`else
    localparam int Attempts = 1;
`endif

    // Bus log tokens; plain bytes are logged as their value.
    localparam int TokS    = 'h100;
    localparam int TokSr   = 'h200;
    localparam int TokP    = 'h300;
    localparam int TokCont = 'h400;

    localparam int PhIdle  = 0;
    localparam int PhReg   = 1;
    localparam int PhGap   = 2;
    localparam int PhWdata = 3;
    localparam int PhRaddr = 4;
    localparam int PhRdata = 5;

    typedef enum int {ModeOk, ModeNackAddr, ModeNackData, ModeArbData} mode_e;

    logic       clk_in = 1'b0;
    logic       reset;
    logic       req_valid;
    logic       req_ready;
    logic       req_rw;
    logic [6:0] req_dev;
    logic [7:0] req_reg;
    logic [7:0] req_wdata;
    logic       resp_valid;
    logic [7:0] resp_rdata;
    logic [1:0] resp_err;
    logic [7:0] m_address;
    logic       m_transfer_start;
    logic       m_transfer_cont;
    logic [7:0] m_data_tx;
    logic       m_transfer_ready;
    logic       m_interrupt;
    logic       m_trans_complete;
    logic       m_nack;
    logic [7:0] m_data_rx;
    logic       m_address_err;
    logic       m_arb_err;

    int    n_tests = 0;
    int    n_fail  = 0;
    int    cyc     = 0;
    int    resp_cnt = 0;
    int    phase;
    int    cnt;
    int    bus_log[$];
    mode_e bus_mode  = ModeOk;
    logic  [7:0] bus_rbyte = 8'h00;
    bit    hang = 1'b0;

    i2c_reg_sequencer #(
        .TIMEOUT_CYCLES(TimeoutCycles),
        .MAX_RETRIES   (MaxRetries)
    ) dut (
        .clk_in          (clk_in),
        .reset           (reset),
        .req_valid       (req_valid),
        .req_ready       (req_ready),
        .req_rw          (req_rw),
        .req_dev         (req_dev),
        .req_reg         (req_reg),
        .req_wdata       (req_wdata),
        .resp_valid      (resp_valid),
        .resp_rdata      (resp_rdata),
        .resp_err        (resp_err),
        .m_address       (m_address),
        .m_transfer_start(m_transfer_start),
        .m_transfer_cont (m_transfer_cont),
        .m_data_tx       (m_data_tx),
        .m_transfer_ready(m_transfer_ready),
        .m_interrupt     (m_interrupt),
        .m_trans_complete(m_trans_complete),
        .m_nack          (m_nack),
        .m_data_rx       (m_data_rx),
        .m_address_err   (m_address_err),
        .m_arb_err       (m_arb_err)
    );

    always #5 clk_in = ~clk_in;

    always @(posedge clk_in) cyc <= cyc + 1;

    always @(negedge clk_in) if (resp_valid) resp_cnt <= resp_cnt + 1;

    // Master + slave responder: logs what goes on the wire and raises interrupts.
    always @(posedge clk_in) begin
        m_interrupt      <= 1'b0;
        m_trans_complete <= 1'b0;
        m_nack           <= 1'b0;
        m_address_err    <= 1'b0;
        m_arb_err        <= 1'b0;
        if (reset) begin
            phase            <= PhIdle;
            cnt              <= 0;
            m_transfer_ready <= 1'b0;
            m_data_rx        <= 8'h00;
        end else if (phase == PhIdle) begin
            m_transfer_ready <= !hang;
            if (m_transfer_start && m_transfer_ready) begin
                bus_log.push_back(TokS);
                bus_log.push_back(int'(m_address));
                m_transfer_ready <= 1'b0;
                phase <= PhReg;
                cnt   <= int'($urandom_range(4, 1));
            end
        end else if (cnt != 0) begin
            cnt <= cnt - 1;
        end else begin
            case (phase)
                PhReg: begin
                    bus_log.push_back(int'(m_data_tx));
                    m_interrupt      <= 1'b1;
                    m_trans_complete <= 1'b1;
                    if (bus_mode == ModeNackAddr) begin
                        m_nack        <= 1'b1;
                        m_address_err <= 1'b1;
                        bus_log.push_back(TokP);
                        phase <= PhIdle;
                    end else begin
                        phase <= PhGap;
                        cnt   <= 2;
                    end
                end
                PhGap: begin
                    if (m_transfer_start) begin
                        bus_log.push_back(TokSr);
                        bus_log.push_back(int'(m_address));
                        phase <= PhRaddr;
                    end else begin
                        phase <= PhWdata;
                    end
                    cnt <= int'($urandom_range(4, 1));
                end
                PhWdata: begin
                    bus_log.push_back(int'(m_data_tx));
                    bus_log.push_back(m_transfer_cont ? TokCont : TokP);
                    m_interrupt      <= 1'b1;
                    m_trans_complete <= 1'b1;
                    if (bus_mode == ModeArbData) begin
                        m_arb_err <= 1'b1;
                        m_nack    <= 1'b1;
                    end else if (bus_mode == ModeNackData) begin
                        m_nack <= 1'b1;
                    end
                    phase <= PhIdle;
                end
                PhRaddr: begin
                    m_interrupt      <= 1'b1;
                    m_trans_complete <= 1'b1;
                    phase <= PhRdata;
                    cnt   <= int'($urandom_range(4, 1));
                end
                PhRdata: begin
                    bus_log.push_back(int'(bus_rbyte));
                    bus_log.push_back(TokP);
                    m_interrupt      <= 1'b1;
                    m_trans_complete <= 1'b1;
                    m_nack           <= 1'b1;
                    m_data_rx        <= bus_rbyte;
                    phase <= PhIdle;
                end
                default: phase <= PhIdle;
            endcase
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic run_access(input string tag, input bit rw, input logic [6:0] dev,
                              input logic [7:0] rg, input logic [7:0] wd, input mode_e mode,
                              input logic [7:0] rb, input bit stall);
        int         exp_log[$];
        int         base;
        int         rc0;
        int         acc_cyc;
        int         waited;
        int         attempts;
        int         got_tok;
        bit         got;
        logic [1:0] exp_err;
        logic [7:0] exp_rd;

        attempts = (mode == ModeOk) ? 1 : Attempts;
        if (!stall) begin
            for (int a = 0; a < attempts; a++) begin
                exp_log.push_back(TokS);
                exp_log.push_back(int'({dev, 1'b0}));
                exp_log.push_back(int'(rg));
                if (mode == ModeNackAddr) begin
                    exp_log.push_back(TokP);
                end else if (!rw) begin
                    exp_log.push_back(int'(wd));
                    exp_log.push_back(TokP);
                end else begin
                    exp_log.push_back(TokSr);
                    exp_log.push_back(int'({dev, 1'b1}));
                    exp_log.push_back(int'(rb));
                    exp_log.push_back(TokP);
                end
            end
        end
        case (mode)
            ModeOk:      exp_err = 2'd0;
            ModeArbData: exp_err = 2'd2;
            default:     exp_err = 2'd1;
        endcase
        if (stall) exp_err = 2'd3;
        exp_rd = (exp_err == 2'd0 && rw) ? rb : 8'h00;

        @(negedge clk_in);
        bus_mode  = mode;
        bus_rbyte = rb;
        hang      = stall;
        base      = bus_log.size();
        rc0       = resp_cnt;
        req_valid = 1'b1;
        req_rw    = rw;
        req_dev   = dev;
        req_reg   = rg;
        req_wdata = wd;
        waited    = 0;
        while (!req_ready && waited < 50) begin
            @(negedge clk_in);
            waited++;
        end
        check_eq({tag, ".ready"}, 32'(req_ready), 32'd1);
        @(posedge clk_in);
        #1;
        acc_cyc   = cyc;
        req_valid = 1'b0;
        req_rw    = ~rw;
        req_dev   = 7'($urandom);
        req_reg   = 8'($urandom);
        req_wdata = 8'($urandom);
        @(negedge clk_in);
        check_eq({tag, ".busy"}, 32'(req_ready), 32'd0);

        got = 1'b0;
        for (int i = 0; i < 600 && !got; i++) begin
            if (resp_valid) got = 1'b1;
            else @(negedge clk_in);
        end
        check_eq({tag, ".resp_seen"}, 32'(got), 32'd1);
        if (got) begin
            check_eq({tag, ".err"}, 32'(resp_err), 32'(exp_err));
            check_eq({tag, ".rdata"}, 32'(resp_rdata), 32'(exp_rd));
            check_eq({tag, ".ready_in_done"}, 32'(req_ready), 32'd0);
            check_eq({tag, ".strobes_in_done"}, 32'({m_transfer_start, m_transfer_cont}), 32'd0);
            if (stall) check_eq({tag, ".timeout_lat"}, 32'(cyc - acc_cyc), 32'(TimeoutCycles));
            @(negedge clk_in);
            check_eq({tag, ".ready_after"}, 32'(req_ready), 32'd1);
        end
        hang = 1'b0;
        repeat (3) @(negedge clk_in);
        check_eq({tag, ".resp_pulses"}, 32'(resp_cnt - rc0), 32'd1);
        check_eq({tag, ".log_len"}, 32'(bus_log.size() - base), 32'(exp_log.size()));
        for (int i = 0; i < exp_log.size(); i++) begin
            got_tok = (base + i < bus_log.size()) ? bus_log[base + i] : -1;
            check_eq($sformatf("%s.log[%0d]", tag, i), 32'(got_tok), 32'(exp_log[i]));
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int   rc0;
        int   waited;
        bit   rw;
        int   r;
        mode_e mode;

        reset     = 1'b1;
        req_valid = 1'b0;
        req_rw    = 1'b0;
        req_dev   = 7'h00;
        req_reg   = 8'h00;
        req_wdata = 8'h00;
        repeat (3) @(negedge clk_in);
        check_eq("rst.req_ready", 32'(req_ready), 32'd1);
        check_eq("rst.resp_valid", 32'(resp_valid), 32'd0);
        check_eq("rst.resp_rdata", 32'(resp_rdata), 32'd0);
        check_eq("rst.resp_err", 32'(resp_err), 32'd0);
        check_eq("rst.strobes", 32'({m_transfer_start, m_transfer_cont}), 32'd0);
        check_eq("rst.m_address", 32'(m_address), 32'd0);
        check_eq("rst.m_data_tx", 32'(m_data_tx), 32'd0);
        reset = 1'b0;
        repeat (2) @(negedge clk_in);

        run_access("wr_1a", 1'b0, 7'h1A, 8'h05, 8'h3C, ModeOk, 8'h00, 1'b0);
        run_access("rd_50", 1'b1, 7'h50, 8'h10, 8'h00, ModeOk, 8'hA5, 1'b0);
        run_access("nack_22", 1'b0, 7'h22, 8'h01, 8'h77, ModeNackAddr, 8'h00, 1'b0);
        run_access("timeout", 1'b0, 7'h33, 8'h02, 8'h11, ModeOk, 8'h00, 1'b1);
        run_access("arb_wdata", 1'b0, 7'h44, 8'h03, 8'h99, ModeArbData, 8'h00, 1'b0);

        // Reset in the middle of the read byte: no response may follow.
        @(negedge clk_in);
        bus_mode  = ModeOk;
        bus_rbyte = 8'h5A;
        rc0       = resp_cnt;
        req_valid = 1'b1;
        req_rw    = 1'b1;
        req_dev   = 7'h50;
        req_reg   = 8'h20;
        @(posedge clk_in);
        #1;
        req_valid = 1'b0;
        waited    = 0;
        while (phase != PhRdata && waited < 100) begin
            @(negedge clk_in);
            waited++;
        end
        check_eq("rst_mid.reached_rdata", 32'(phase == PhRdata), 32'd1);
        @(negedge clk_in);
        reset = 1'b1;
        @(negedge clk_in);
        reset = 1'b0;
        check_eq("rst_mid.ready", 32'(req_ready), 32'd1);
        check_eq("rst_mid.strobes", 32'({m_transfer_start, m_transfer_cont}), 32'd0);
        repeat (4) @(negedge clk_in);
        check_eq("rst_mid.no_resp", 32'(resp_cnt - rc0), 32'd0);
        run_access("after_rst_wr", 1'b0, 7'h2B, 8'h44, 8'hC3, ModeOk, 8'h00, 1'b0);

        for (int n = 0; n < 24; n++) begin
            rw = 1'($urandom_range(1, 0));
            r  = int'($urandom_range(9, 0));
            if (r < 6) mode = ModeOk;
            else if (r < 8) mode = ModeNackAddr;
            else if (rw) mode = ModeOk;
            else if (r == 8) mode = ModeNackData;
            else mode = ModeArbData;
            run_access($sformatf("rnd%0d", n), rw, 7'($urandom), 8'($urandom), 8'($urandom),
                       mode, 8'($urandom), 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
